// File: rtl/sdram_init_sequencer_pkg.sv
// Purpose: shared types and command encodings for SDRAM power-up sequencing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdram_init_pkg;

    // Init FSM states; every wait state is timed by one shared down-counter.
    typedef enum logic [3:0] {
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_POWERUP,
        ST_PRECHARGE,
        ST_WAIT_TRP,
        ST_REFRESH,
        ST_WAIT_TRFC,
        ST_LOAD_MODE,
        ST_WAIT_TMRD,
        ST_DONE
    } init_state_t;

    // Command word {cs_n, ras_n, cas_n, we_n}; also used by the SDRAM controller.
    localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_LMR       = 4'b0000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_init_sequencer_if.sv
// Purpose: SDRAM pin bundle (CKE, command, address, bank, DQM).
// Latency: n/a (wiring only); master drives the pins, slave observes them.
// Backpressure: none; the pins are a free-running command bus.
interface sdram_init_sequencer_if;
    logic        s_cke;
    logic        s_cs_n;
    logic        s_ras_n;
    logic        s_cas_n;
    logic        s_we_n;
    logic [12:0] s_addr;
    logic [1:0]  s_ba;
    logic [1:0]  s_dqm;

    modport master (
        output s_cke, s_cs_n, s_ras_n, s_cas_n, s_we_n, s_addr, s_ba, s_dqm
    );

    modport slave (
        input  s_cke, s_cs_n, s_ras_n, s_cas_n, s_we_n, s_addr, s_ba, s_dqm
    );
endinterface

// File: rtl/sdram_init_sequencer_bit_sync.sv
// Purpose: 2-flop synchroniser for a single asynchronous level.
// Latency: 2 clk edges from input change to q.
// Backpressure: none.
// Ports: clk, reset (sync, active-high, clears both flops), d (async in), q (synced out).
module bit_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sdram_init_sequencer.sv
// Purpose: drives the SDRAM power-up sequence (lock wait, 200us NOP, PRE-ALL,
//          N x REFRESH, LMR), then raises init_done and releases sys_reset.
// Latency: pll_locked -> lock_s 2 edges, lock loss -> INHIBIT on pins 3 edges.
// Backpressure: none; the sequencer owns the pins until init_done.
// Ports: clk, reset (sync active-high), pll_locked (async), init_done,
//        sys_reset (registered ~init_done), sdram (SDRAM pin bundle, master).
module sdram_init_sequencer
    import sdram_init_pkg::*;
#(
    parameter int          CLK_FREQ_MHZ       = 80,
    parameter int          POWERUP_US         = 200,
    parameter int          LOCK_STABLE_CYCLES = 1024,
    parameter int          TRP_CYCLES         = 2,
    parameter int          TRFC_CYCLES        = 7,
    parameter int          TMRD_CYCLES        = 2,
    parameter int          REFRESH_COUNT      = 8,
    parameter logic [12:0] MODE_REG           = 13'h0021
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pll_locked,
    output logic                   init_done,
    output logic                   sys_reset,
    sdram_init_sequencer_if.master sdram
);

    localparam int PWR_CYCLES = CLK_FREQ_MHZ * POWERUP_US;
    localparam int CNT_W      = $clog2(max2(LOCK_STABLE_CYCLES, PWR_CYCLES)) + 1;
    localparam int REF_W      = $clog2(REFRESH_COUNT + 1);

    // Counter load values: terminal-minus-one. The t* waits follow a one-cycle
    // command state, so the wait itself spans (t - 1) cycles and loads t - 2.
    localparam logic [CNT_W-1:0] LD_STABLE = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_PWR    = CNT_W'(PWR_CYCLES - 1);
    localparam logic [CNT_W-1:0] LD_TRP    = CNT_W'(TRP_CYCLES - 2);
    localparam logic [CNT_W-1:0] LD_TRFC   = CNT_W'(TRFC_CYCLES - 2);
    localparam logic [CNT_W-1:0] LD_TMRD   = CNT_W'(TMRD_CYCLES - 2);
    localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REFRESH_COUNT - 1);

    localparam logic [12:0] ADDR_PRE_ALL = 13'h0400;  // A10 selects all banks

    logic              lock_s;
    init_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [REF_W-1:0]  ref_cnt;
    logic              cke;
    logic [3:0]        cmd;
    logic [12:0]       addr;
    logic [1:0]        ba;

    bit_sync u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_locked),
        .q     (lock_s)
    );

    // Outputs are loaded together with the state they belong to, so the pins
    // always show the command of the state currently held.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_WAIT_LOCK;
            cnt       <= '0;
            ref_cnt   <= '0;
            cke       <= 1'b0;
            cmd       <= CMD_INHIBIT;
            addr      <= '0;
            ba        <= '0;
            init_done <= 1'b0;
            sys_reset <= 1'b1;
        end else begin
            sys_reset <= ~init_done;
            if (state != ST_WAIT_LOCK && !lock_s) begin
                // Lock lost: abandon the sequence and release the pins.
                state     <= ST_WAIT_LOCK;
                cnt       <= '0;
                ref_cnt   <= '0;
                cke       <= 1'b0;
                cmd       <= CMD_INHIBIT;
                addr      <= '0;
                ba        <= '0;
                init_done <= 1'b0;
            end else begin
                cmd  <= CMD_NOP;
                addr <= '0;
                ba   <= '0;
                case (state)
                    ST_WAIT_LOCK: begin
                        cmd <= CMD_INHIBIT;
                        if (lock_s) begin
                            state <= ST_STABLE;
                            cnt   <= LD_STABLE;
                        end
                    end
                    ST_STABLE: begin
                        cmd <= CMD_INHIBIT;
                        if (cnt == '0) begin
                            state <= ST_POWERUP;
                            cnt   <= LD_PWR;
                            cke   <= 1'b1;
                            cmd   <= CMD_NOP;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_POWERUP: begin
                        if (cnt == '0) begin
                            state <= ST_PRECHARGE;
                            cmd   <= CMD_PRECHARGE;
                            addr  <= ADDR_PRE_ALL;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_PRECHARGE: begin
                        state <= ST_WAIT_TRP;
                        cnt   <= LD_TRP;
                    end
                    ST_WAIT_TRP: begin
                        if (cnt == '0) begin
                            state   <= ST_REFRESH;
                            cmd     <= CMD_REFRESH;
                            ref_cnt <= '0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_REFRESH: begin
                        state <= ST_WAIT_TRFC;
                        cnt   <= LD_TRFC;
                    end
                    ST_WAIT_TRFC: begin
                        if (cnt == '0) begin
                            // ref_cnt holds the index of the refresh just issued.
                            if (ref_cnt == REF_LAST) begin
                                state <= ST_LOAD_MODE;
                                cmd   <= CMD_LMR;
                                addr  <= MODE_REG;
                            end else begin
                                state   <= ST_REFRESH;
                                cmd     <= CMD_REFRESH;
                                ref_cnt <= ref_cnt + REF_W'(1);
                            end
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_LOAD_MODE: begin
                        state <= ST_WAIT_TMRD;
                        cnt   <= LD_TMRD;
                    end
                    ST_WAIT_TMRD: begin
                        if (cnt == '0) begin
                            state     <= ST_DONE;
                            init_done <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    ST_DONE: begin
                        // Holds NOP/CKE=1; the controller takes the bus from here.
                    end
                    default: begin
                        state <= ST_WAIT_LOCK;
                        cmd   <= CMD_INHIBIT;
                        cke   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sdram.s_cke   = cke;
    assign sdram.s_cs_n  = cmd[3];
    assign sdram.s_ras_n = cmd[2];
    assign sdram.s_cas_n = cmd[1];
    assign sdram.s_we_n  = cmd[0];
    assign sdram.s_addr  = addr;
    assign sdram.s_ba    = ba;
    assign sdram.s_dqm   = 2'b11;  // data path is idle for the whole sequence

endmodule

// File: tb/tb_sdram_init_sequencer.sv
// Purpose: self-checking bench for sdram_init_sequencer using an event scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_sdram_init_sequencer;
    import sdram_init_pkg::*;

    localparam int CLK_MHZ    = 80;
    localparam int PWR_US     = 1;
    localparam int STABLE_CYC = 16;
    localparam int TRP        = 2;
    localparam int TRFC       = 7;
    localparam int TMRD       = 2;
    localparam int REFRESH_N  = 8;
    localparam int PWR_CYC    = CLK_MHZ * PWR_US;
    localparam int SYNC_LAT   = 2;

    localparam int EV_CKE    = 0;
    localparam int EV_PRE    = 1;
    localparam int EV_REF    = 2;
    localparam int EV_LMR    = 3;
    localparam int EV_DONE   = 4;
    localparam int EV_SYSREL = 5;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic pll_locked;
    logic init_done;
    logic sys_reset;

    sdram_init_sequencer_if sd ();

    sdram_init_sequencer #(
        .CLK_FREQ_MHZ       (CLK_MHZ),
        .POWERUP_US         (PWR_US),
        .LOCK_STABLE_CYCLES (STABLE_CYC),
        .TRP_CYCLES         (TRP),
        .TRFC_CYCLES        (TRFC),
        .TMRD_CYCLES        (TMRD),
        .REFRESH_COUNT      (REFRESH_N),
        .MODE_REG           (13'h0021)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pll_locked (pll_locked),
        .init_done  (init_done),
        .sys_reset  (sys_reset),
        .sdram      (sd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t  exp_q[$];
    int   tests = 0;
    int   failed = 0;
    int   ref_seen = 0;
    int   chk_bad = 0;
    int   chk_cycles = 0;
    logic prev_cke = 1'b0;
    logic prev_done = 1'b0;
    logic prev_sysrst = 1'b1;

    function automatic logic [3:0] cur_cmd();
        return {sd.s_cs_n, sd.s_ras_n, sd.s_cas_n, sd.s_we_n};
    endfunction

    // Expected protocol events for a lock first sampled on edge t0.
    task automatic push_seq(input int t0, input bit with_sysrel);
        int pre;
        int lmr;
        pre = t0 + SYNC_LAT + STABLE_CYC + PWR_CYC;
        lmr = pre + TRP + REFRESH_N * TRFC;
        exp_q.push_back('{EV_CKE, t0 + SYNC_LAT + STABLE_CYC});
        exp_q.push_back('{EV_PRE, pre});
        for (int k = 0; k < REFRESH_N; k++)
            exp_q.push_back('{EV_REF, pre + TRP + k * TRFC});
        exp_q.push_back('{EV_LMR, lmr});
        exp_q.push_back('{EV_DONE, lmr + TMRD});
        if (with_sysrel)
            exp_q.push_back('{EV_SYSREL, lmr + TMRD + 1});
    endtask

    // Pop the next expected event and compare it with what the pins show now.
    task automatic sb_event(input int kind);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL sb_unexpected: event %0d at cycle %0d, required none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.cyc !== cyc ||
                (kind == EV_PRE && sd.s_addr[10] !== 1'b1) ||
                (kind == EV_LMR && (sd.s_addr !== 13'h0021 || sd.s_ba !== 2'd0))) begin
                failed++;
                $display("FAIL sb_event: got kind=%0d cyc=%0d addr=%h ba=%0d, required kind=%0d cyc=%0d",
                         kind, cyc, sd.s_addr, sd.s_ba, e.kind, e.cyc);
            end
        end
    endtask

    // Advance to the next falling edge, run the pin checker and feed events.
    task automatic step();
        logic [3:0] c;
        @(negedge clk);
        c = cur_cmd();
        if (init_done !== 1'b1) begin
            chk_cycles++;
            if (sd.s_dqm !== 2'b11 ||
                !(c === CMD_INHIBIT || c === CMD_NOP || c === CMD_PRECHARGE ||
                  c === CMD_REFRESH || c === CMD_LMR) ||
                (sd.s_cke !== 1'b1 && c !== CMD_INHIBIT)) begin
                if (chk_bad == 0)
                    $display("[TB] illegal pins at cycle %0d: cmd=%b cke=%b dqm=%b", cyc, c, sd.s_cke, sd.s_dqm);
                chk_bad++;
            end
        end
        if (sd.s_cke === 1'b1 && prev_cke !== 1'b1) sb_event(EV_CKE);
        if (c === CMD_PRECHARGE) sb_event(EV_PRE);
        if (c === CMD_REFRESH) begin
            ref_seen++;
            sb_event(EV_REF);
        end
        if (c === CMD_LMR) sb_event(EV_LMR);
        if (init_done === 1'b1 && prev_done !== 1'b1) sb_event(EV_DONE);
        if (sys_reset === 1'b0 && prev_sysrst !== 1'b0) sb_event(EV_SYSREL);
        prev_cke    = sd.s_cke;
        prev_done   = init_done;
        prev_sysrst = sys_reset;
    endtask

    task automatic run_until_empty(input int budget, input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL %s_timeout: %0d events pending after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic check_refs(input string name, input int required);
        tests++;
        if (ref_seen !== required) begin
            failed++;
            $display("FAIL %s_refresh_count: got %0d, required %0d", name, ref_seen, required);
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        reset = 1'b1;
        pll_locked = 1'b0;
        repeat (3) step();
        tests += 7;
        if (init_done !== 1'b0) begin failed++; $display("FAIL rst_init_done: got %b, required 0", init_done); end
        if (sys_reset !== 1'b1) begin failed++; $display("FAIL rst_sys_reset: got %b, required 1", sys_reset); end
        if (sd.s_cke !== 1'b0) begin failed++; $display("FAIL rst_cke: got %b, required 0", sd.s_cke); end
        if (cur_cmd() !== CMD_INHIBIT) begin failed++; $display("FAIL rst_cmd: got %b, required %b", cur_cmd(), CMD_INHIBIT); end
        if (sd.s_addr !== 13'd0) begin failed++; $display("FAIL rst_addr: got %h, required 0", sd.s_addr); end
        if (sd.s_ba !== 2'd0) begin failed++; $display("FAIL rst_ba: got %0d, required 0", sd.s_ba); end
        if (sd.s_dqm !== 2'b11) begin failed++; $display("FAIL rst_dqm: got %b, required 11", sd.s_dqm); end
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (init_done !== 1'b0 || sys_reset !== 1'b1 || sd.s_cke !== 1'b0 ||
                cur_cmd() !== CMD_INHIBIT || sd.s_addr !== 13'd0 || sd.s_ba !== 2'd0)
                bad++;
        end
        tests++;
        if (bad !== 0) begin
            failed++;
            $display("FAIL idle_no_lock: %0d cycles off reset values, required 0", bad);
        end
    endtask

    task automatic test_power_up();
        int t0;
        pll_locked = 1'b1;
        t0 = cyc + 1;
        push_seq(t0, 1'b1);
        ref_seen = 0;
        run_until_empty(400, "power_up");
        check_refs("power_up", REFRESH_N);
    endtask

    task automatic test_stable_dropout();
        int d;
        int t0;
        int r;
        // Lock loss while DONE: init_done falls, sys_reset rises one edge later.
        pll_locked = 1'b0;
        d = cyc + 1;
        while (cyc < d + 2) step();
        tests++;
        if (init_done !== 1'b0) begin failed++; $display("FAIL done_lock_loss_init_done: got %b, required 0", init_done); end
        step();
        tests++;
        if (sys_reset !== 1'b1) begin failed++; $display("FAIL done_lock_loss_sys_reset: got %b, required 1", sys_reset); end
        repeat (3) step();
        pll_locked = 1'b1;
        t0 = cyc + 1;
        while (cyc < t0 + 9) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        r = cyc + 1;
        push_seq(r, 1'b1);
        ref_seen = 0;
        run_until_empty(400, "stable_dropout");
        check_refs("stable_dropout", REFRESH_N);
    endtask

    task automatic test_lock_loss_refresh();
        int t0;
        int d;
        int n = 0;
        pll_locked = 1'b0;
        repeat (4) step();
        pll_locked = 1'b1;
        t0 = cyc + 1;
        push_seq(t0, 1'b0);
        ref_seen = 0;
        while (ref_seen < 4 && n < 300) begin
            step();
            n++;
        end
        check_refs("to_4th_refresh", 4);
        step();
        pll_locked = 1'b0;
        d = cyc + 1;
        exp_q.delete();
        while (cyc < d + 1) step();
        tests++;
        if (sd.s_cke !== 1'b1) begin failed++; $display("FAIL lock_loss_early: cke got %b at edge+1, required 1", sd.s_cke); end
        step();
        tests++;
        if (sd.s_cke !== 1'b0 || cur_cmd() !== CMD_INHIBIT || init_done !== 1'b0) begin
            failed++;
            $display("FAIL lock_loss_pins: cke=%b cmd=%b init_done=%b, required 0/%b/0", sd.s_cke, cur_cmd(), init_done, CMD_INHIBIT);
        end
        repeat (3) step();
        pll_locked = 1'b1;
        t0 = cyc + 1;
        push_seq(t0, 1'b0);
        ref_seen = 0;
        run_until_empty(400, "lock_loss_rerun");
        check_refs("lock_loss_rerun", REFRESH_N);
    endtask

    // Entered right after the DONE event of the previous run was observed.
    task automatic test_reset_after_done();
        int t0;
        reset = 1'b1;
        step();
        tests++;
        if (init_done !== 1'b0 || sys_reset !== 1'b1) begin
            failed++;
            $display("FAIL reset_after_done: init_done=%b sys_reset=%b, required 0/1", init_done, sys_reset);
        end
        tests++;
        if (sd.s_cke !== 1'b0 || cur_cmd() !== CMD_INHIBIT) begin
            failed++;
            $display("FAIL reset_after_done_pins: cke=%b cmd=%b, required 0/%b", sd.s_cke, cur_cmd(), CMD_INHIBIT);
        end
        reset = 1'b0;
        t0 = cyc + 1;
        push_seq(t0, 1'b1);
        ref_seen = 0;
        run_until_empty(400, "reset_rerun");
        check_refs("reset_rerun", REFRESH_N);
    endtask

    task automatic test_command_checker();
        tests++;
        if (chk_bad !== 0 || chk_cycles < 500) begin
            failed++;
            $display("FAIL cmd_checker: %0d bad of %0d init cycles, required 0 bad of >=500", chk_bad, chk_cycles);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        pll_locked = 1'b0;
        test_reset();
        test_power_up();
        test_stable_dropout();
        test_lock_loss_refresh();
        test_reset_after_done();
        test_command_checker();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
